qpu_exu_cwbck_arb: RTL

Classical-register-file write-back arbiter for the QPU execution unit. It merges the single-cycle ALU write-back stream (`cwbck`) with the long-pipe LSU load write-back stream into the one CRF write port. Long-pipe results are buffered in a small FIFO, and each long-pipe write-back emits a retire pulse to the OITF. It sits between `QPU_exu_alu`/LSU-ctrl and the CRF, beside the OITF.

---
 rtl/qpu_exu_cwbck_arb_pkg.sv | 35 +++
 rtl/qpu_exu_lpb_fifo.sv | 91 +++++++++
 rtl/qpu_exu_cwbck_arb.sv | 127 ++++++++++++
 3 files changed

// File: rtl/qpu_exu_cwbck_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : qpu_exu_cwbck_arb_pkg
//  Purpose : Shared defaults and types for the CRF write-back arbiter slice.
//            Supplies the QPU width defines when the shared define file has
//            not been read first, the default parameter values, and the
//            write-port source encoding.
//  Ports   : none (package)
//  Revision: 1.0 - initial release
// ============================================================================
`ifndef QPU_XLEN
`define QPU_XLEN 32
`endif
`ifndef QPU_RFIDX_REAL_WIDTH
`define QPU_RFIDX_REAL_WIDTH 5
`endif
`ifndef QPU_ITAG_WIDTH
`define QPU_ITAG_WIDTH 1
`endif

package qpu_exu_cwbck_arb_pkg;

  localparam int DEF_LPB_DEPTH  = 2;
  localparam int DEF_STARVE_MAX = 4;

  // Which stream owns the CRF write port in the current cycle.
  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_ALU  = 2'd1,
    SRC_LPB  = 2'd2
  } wbck_src_e;

endpackage

`default_nettype wire

// File: rtl/qpu_exu_lpb_fifo.sv
`default_nettype none
// ============================================================================
//  Module  : qpu_exu_lpb_fifo
//  Purpose : Long-pipe buffer. Circular FIFO holding data, destination index
//            and OITF tag of completed loads until the write port is free.
//  Ports   : clk, rst_n             - clock, async active-low reset
//            push_valid/push_ready  - enqueue handshake (ready = not full)
//            push_data/rdidx/itag   - entry payload
//            head_valid             - head entry present
//            head_data/rdidx/itag   - head entry payload
//            pop                    - dequeue head (ignored when empty)
//            empty                  - no entries held
//  Revision: 1.0 - initial release
// ============================================================================
module qpu_exu_lpb_fifo #(
  parameter int DEPTH   = 2,   // power of two, >= 2
  parameter int XLEN    = 32,
  parameter int RFIDX_W = 5,
  parameter int ITAG_W  = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               push_valid,
  output logic               push_ready,
  input  logic [XLEN-1:0]    push_data,
  input  logic [RFIDX_W-1:0] push_rdidx,
  input  logic [ITAG_W-1:0]  push_itag,
  output logic               head_valid,
  output logic [XLEN-1:0]    head_data,
  output logic [RFIDX_W-1:0] head_rdidx,
  output logic [ITAG_W-1:0]  head_itag,
  input  logic               pop,
  output logic               empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [XLEN-1:0]    data_mem  [DEPTH];
  logic [RFIDX_W-1:0] rdidx_mem [DEPTH];
  logic [ITAG_W-1:0]  itag_mem  [DEPTH];

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign full       = (count == CNT_W'(DEPTH));
  assign empty      = (count == '0);
  // Ready comes from the registered count only, so a push is refused while
  // full even when the head is popped in the same cycle.
  assign push_ready = ~full;
  assign do_push    = push_valid & ~full;
  assign do_pop     = pop & ~empty;

  assign head_valid = ~empty;
  assign head_data  = data_mem[rd_ptr];
  assign head_rdidx = rdidx_mem[rd_ptr];
  assign head_itag  = itag_mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Payload storage needs no reset: it is only observed through head_valid.
  always_ff @(posedge clk) begin
    if (do_push) begin
      data_mem[wr_ptr]  <= push_data;
      rdidx_mem[wr_ptr] <= push_rdidx;
      itag_mem[wr_ptr]  <= push_itag;
    end
  end

endmodule

`default_nettype wire

// File: rtl/qpu_exu_cwbck_arb.sv
`default_nettype none
// ============================================================================
//  Module  : qpu_exu_cwbck_arb
//  Purpose : CRF write-back arbiter. Merges the single-cycle ALU write-back
//            stream with buffered long-pipe (LSU) results onto the one CRF
//            write port, and retires long-pipe results to the OITF.
//  Ports   : clk, rst_n                    - clock, async active-low reset
//            alu_wbck_i_valid/ready/data/rdidx
//                                          - ALU write-back (0-cycle path)
//            lsu_wbck_i_valid/ready/data/rdidx/itag
//                                          - long-pipe result into buffer
//            rf_wbck_o_ena/wdat/rdidx      - CRF write port
//            oitf_ret_ena/itag             - OITF retire pulse and tag
//            lpb_empty                     - long-pipe buffer empty
//  Revision: 1.0 - initial release
// ============================================================================
module qpu_exu_cwbck_arb
  import qpu_exu_cwbck_arb_pkg::*;
#(
  parameter int XLEN       = `QPU_XLEN,
  parameter int RFIDX_W    = `QPU_RFIDX_REAL_WIDTH,
  parameter int ITAG_W     = `QPU_ITAG_WIDTH,
  parameter int LPB_DEPTH  = DEF_LPB_DEPTH,
  parameter int STARVE_MAX = DEF_STARVE_MAX
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               alu_wbck_i_valid,
  output logic               alu_wbck_i_ready,
  input  logic [XLEN-1:0]    alu_wbck_i_data,
  input  logic [RFIDX_W-1:0] alu_wbck_i_rdidx,
  input  logic               lsu_wbck_i_valid,
  output logic               lsu_wbck_i_ready,
  input  logic [XLEN-1:0]    lsu_wbck_i_data,
  input  logic [RFIDX_W-1:0] lsu_wbck_i_rdidx,
  input  logic [ITAG_W-1:0]  lsu_wbck_i_itag,
  output logic               rf_wbck_o_ena,
  output logic [XLEN-1:0]    rf_wbck_o_wdat,
  output logic [RFIDX_W-1:0] rf_wbck_o_rdidx,
  output logic               oitf_ret_ena,
  output logic [ITAG_W-1:0]  oitf_ret_itag,
  output logic               lpb_empty
);

  localparam int STARVE_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

  logic               head_valid;
  logic [XLEN-1:0]    head_data;
  logic [RFIDX_W-1:0] head_rdidx;
  logic [ITAG_W-1:0]  head_itag;
  logic               lpb_gnt;
  logic               alu_gnt;
  logic               starve_hit;
  logic [STARVE_W-1:0] starve_cnt;
  wbck_src_e          src;

  qpu_exu_lpb_fifo #(
    .DEPTH   (LPB_DEPTH),
    .XLEN    (XLEN),
    .RFIDX_W (RFIDX_W),
    .ITAG_W  (ITAG_W)
  ) u_lpb (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_valid (lsu_wbck_i_valid),
    .push_ready (lsu_wbck_i_ready),
    .push_data  (lsu_wbck_i_data),
    .push_rdidx (lsu_wbck_i_rdidx),
    .push_itag  (lsu_wbck_i_itag),
    .head_valid (head_valid),
    .head_data  (head_data),
    .head_rdidx (head_rdidx),
    .head_itag  (head_itag),
    .pop        (lpb_gnt),
    .empty      (lpb_empty)
  );

  // The ALU has priority, except when it has already won STARVE_MAX
  // consecutive times against a waiting buffer entry.
  assign starve_hit       = (starve_cnt == STARVE_W'(STARVE_MAX));
  assign lpb_gnt          = head_valid & (~alu_wbck_i_valid | starve_hit);
  assign alu_gnt          = alu_wbck_i_valid & ~lpb_gnt;
  assign alu_wbck_i_ready = ~lpb_gnt;

  always_comb begin
    src = SRC_NONE;
    if (lpb_gnt)      src = SRC_LPB;
    else if (alu_gnt) src = SRC_ALU;
  end

  always_comb begin
    rf_wbck_o_wdat  = '0;
    rf_wbck_o_rdidx = '0;
    case (src)
      SRC_ALU: begin
        rf_wbck_o_wdat  = alu_wbck_i_data;
        rf_wbck_o_rdidx = alu_wbck_i_rdidx;
      end
      SRC_LPB: begin
        rf_wbck_o_wdat  = head_data;
        rf_wbck_o_rdidx = head_rdidx;
      end
      default: begin
        rf_wbck_o_wdat  = '0;
        rf_wbck_o_rdidx = '0;
      end
    endcase
  end

  // A write to x0 is still consumed (and retired for loads), just not written.
  assign rf_wbck_o_ena = (src != SRC_NONE) & (|rf_wbck_o_rdidx);
  assign oitf_ret_ena  = lpb_gnt;
  assign oitf_ret_itag = lpb_gnt ? head_itag : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if (lpb_gnt | ~head_valid) begin
      starve_cnt <= '0;
    end else if (alu_gnt & ~starve_hit) begin
      starve_cnt <= starve_cnt + STARVE_W'(1);
    end
  end

endmodule

`default_nettype wire
